// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, frame size, FSM states, baud divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;
  localparam logic UART_IDLE_LVL  = 1'b1;

  // Frame sequencing states, shared by the transmitter and the planned receiver.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Write-side bus of the buffered UART transmitter: byte push plus queue status.
// Latency: n/a (wiring only).
// Backpressure: producer must watch full; writes while full are dropped and flagged.
interface uart_tx_buffered_if #(
  parameter int FIFO_DEPTH = 16
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic [CW-1:0] count;
  logic          busy;
  logic          overflow;

  modport master (
    output wr_en, wr_data,
    input  full, count, busy, overflow
  );

  modport slave (
    input  wr_en, wr_data,
    output full, count, busy, overflow
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; head word is visible combinationally.
// Latency: a pushed word is at the head on the cycle after the push edge when empty.
// Backpressure: push ignored while full, pop ignored while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign pop_data = mem[rd_ptr];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  // Storage array; contents need no reset because the counter guards reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-2 depth; the counter tells full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed from a byte FIFO, with built-in baud divider.
// Latency: byte written into an empty queue while idle starts its start bit one clock later.
// Backpressure: full flags a saturated queue; writes while full are dropped and set sticky overflow.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_tx_buffered_if.slave     bus,
  output logic                  tx
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int IW  = $clog2(UART_DATA_BITS);

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx_buffered: CLK_HZ/BAUD gives fewer than 2 clocks per bit");
  end

  uart_state_e                 state;
  logic [BW-1:0]               baud_cnt;
  logic [IW-1:0]               bit_idx;
  logic [UART_DATA_BITS-1:0]   shift_q;
  logic                        tx_q;
  logic                        busy_q;
  logic                        ovf_q;

  logic                        baud_end;
  logic                        push;
  logic                        pop;
  logic [7:0]                  head;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [CW-1:0]               fifo_count;

  assign baud_end = (baud_cnt == BW'(DIV - 1));
  assign push     = bus.wr_en & ~fifo_full;

  // Only an idle line or the final clock of a stop bit may take the next byte.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      pop = (state == IDLE) || ((state == STOP) && baud_end);
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (bus.wr_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Frame sequencer: baud counting, shifting and the registered line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      tx_q     <= UART_IDLE_LVL;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            shift_q <= head;
            state   <= START;
            tx_q    <= UART_START_LVL;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx_q     <= shift_q[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == IW'(UART_DATA_BITS - 1)) begin
              state <= STOP;
              tx_q  <= UART_STOP_LVL;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (pop) begin
              // Back-to-back frames: no idle bit between stop and next start.
              shift_q <= head;
              state   <= START;
              tx_q    <= UART_START_LVL;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          tx_q   <= UART_IDLE_LVL;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow: any write attempt against a full queue is remembered until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (bus.wr_en && fifo_full) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.full     = fifo_full;
  assign bus.count    = fifo_count;
  assign bus.busy     = busy_q;
  assign bus.overflow = ovf_q;
  assign tx           = tx_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: bit-level frame checks plus a serial receiver model.
// Latency: n/a.
// Backpressure: exercises full, overflow and write-on-pop behaviour.
module tb_uart_tx_buffered;

  logic clk;
  logic rst_n;
  logic tx0;
  logic tx1;

  uart_tx_buffered_if #(.FIFO_DEPTH(16)) bus0 ();
  uart_tx_buffered_if #(.FIFO_DEPTH(16)) bus1 ();

  // DIV = 10
  uart_tx_buffered #(.CLK_HZ(1152000), .BAUD(115200), .FIFO_DEPTH(16)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0),
    .tx    (tx0)
  );

  // DIV = 9 (rounded from 8.68)
  uart_tx_buffered #(.CLK_HZ(1000000), .BAUD(115200), .FIFO_DEPTH(16)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1),
    .tx    (tx1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  logic [7:0]  rx_q[$];
  logic [31:0] line_acc  = '0;
  logic [31:0] last_line = '0;

  // Receiver model for dut0 (10 clocks per bit): samples each bit at its centre.
  initial begin
    logic [7:0] b;
    logic       ok;
    forever begin
      @(negedge tx0);
      repeat (5) @(posedge clk);
      #2;
      ok = (tx0 == 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (10) @(posedge clk);
        #2;
        b[i] = tx0;
      end
      repeat (10) @(posedge clk);
      #2;
      ok = ok && (tx0 == 1'b1);
      if (ok) begin
        rx_q.push_back(b);
        if (b == 8'h0D || b == 8'h0A) begin
          last_line = line_acc;
          line_acc  = '0;
        end else begin
          line_acc = {line_acc[23:0], b};
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one write that lands on the next rising edge; returns just after it.
  task automatic write0(input logic [7:0] d);
    bus0.wr_en   = 1'b1;
    bus0.wr_data = d;
    step(1);
    bus0.wr_en   = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // bit i = i-th transmitted bit: start, d0..d7, stop
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [9:0] frm;
    int lo;
    int bz;
    int low_seen;

    vecs[0] = '{8'h55, 10'b1010101010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'hA3, 10'b1101000110};
    vecs[4] = '{8'h0D, 10'b1000011010};

    rst_n        = 1'b0;
    bus0.wr_en   = 1'b0;
    bus0.wr_data = '0;
    bus1.wr_en   = 1'b0;
    bus1.wr_data = '0;
    step(3);

    // Reset state
    check("rst_tx",       {31'd0, tx0},           32'd1);
    check("rst_busy",     {31'd0, bus0.busy},     32'd0);
    check("rst_full",     {31'd0, bus0.full},     32'd0);
    check("rst_count",    {27'd0, bus0.count},    32'd0);
    check("rst_overflow", {31'd0, bus0.overflow}, 32'd0);
    check("rst_tx1",      {31'd0, tx1},           32'd1);
    rst_n = 1'b1;
    step(3);

    // Single-byte frames, bit by bit
    for (int v = 0; v < 5; v++) begin
      rx_q.delete();
      frm = vecs[v].frame;
      write0(vecs[v].data);
      check($sformatf("v%0d_count_wr", v), {27'd0, bus0.count}, 32'd1);
      check($sformatf("v%0d_tx_N", v), {31'd0, tx0}, 32'd1);
      step(1);
      check($sformatf("v%0d_busy_N1", v), {31'd0, bus0.busy}, 32'd1);
      check($sformatf("v%0d_count_pop", v), {27'd0, bus0.count}, 32'd0);
      step(5);
      for (int i = 0; i < 10; i++) begin
        if (i > 0) step(10);
        check($sformatf("v%0d_bit%0d", v, i), {31'd0, tx0}, {31'd0, frm[i]});
      end
      step(4);
      check($sformatf("v%0d_busy_N100", v), {31'd0, bus0.busy}, 32'd1);
      step(1);
      check($sformatf("v%0d_busy_N101", v), {31'd0, bus0.busy}, 32'd0);
      step(20);
      check($sformatf("v%0d_rx_n", v), rx_q.size(), 32'd1);
      if (rx_q.size() > 0) check($sformatf("v%0d_rx_data", v), {24'd0, rx_q[0]}, {24'd0, vecs[v].data});
    end

    // "HI\r" in three consecutive cycles: contiguous frames
    rx_q.delete();
    bus0.wr_en   = 1'b1;
    bus0.wr_data = 8'h48;
    step(1);                          // edge N
    bus0.wr_data = 8'h49;
    step(1);                          // N+1
    check("hi_tx_N1", {31'd0, tx0}, 32'd0);
    bus0.wr_data = 8'h0D;
    step(1);                          // N+2
    bus0.wr_en = 1'b0;
    check("hi_count_peak", {27'd0, bus0.count}, 32'd2);
    step(98);
    check("hi_stop1", {31'd0, tx0}, 32'd1);
    step(1);
    check("hi_start2", {31'd0, tx0}, 32'd0);
    check("hi_count2", {27'd0, bus0.count}, 32'd1);
    step(99);
    check("hi_stop2", {31'd0, tx0}, 32'd1);
    step(1);
    check("hi_start3", {31'd0, tx0}, 32'd0);
    check("hi_count3", {27'd0, bus0.count}, 32'd0);
    step(99);
    check("hi_busy_N300", {31'd0, bus0.busy}, 32'd1);
    step(1);
    check("hi_busy_N301", {31'd0, bus0.busy}, 32'd0);
    step(10);
    check("hi_rx_n", rx_q.size(), 32'd3);
    check("hi_line", last_line, 32'h0000_4849);

    // Write on the STOP->START pop edge while full
    write0(8'hC0);                    // edge M
    step(1);                          // M+1: popped
    for (int k = 0; k < 16; k++) begin
      bus0.wr_en   = 1'b1;
      bus0.wr_data = 8'h20 + 8'(k);
      step(1);                        // M+2 .. M+17
    end
    bus0.wr_en = 1'b0;
    check("wp_full",     {31'd0, bus0.full},     32'd1);
    check("wp_count16",  {27'd0, bus0.count},    32'd16);
    check("wp_ovf_pre",  {31'd0, bus0.overflow}, 32'd0);
    step(83);                         // M+100
    bus0.wr_en   = 1'b1;
    bus0.wr_data = 8'hEE;
    step(1);                          // M+101: pop edge
    bus0.wr_en = 1'b0;
    check("wp_ovf",      {31'd0, bus0.overflow}, 32'd1);
    check("wp_count15",  {27'd0, bus0.count},    32'd15);
    check("wp_not_full", {31'd0, bus0.full},     32'd0);
    check("wp_start",    {31'd0, tx0},           32'd0);

    // Asynchronous reset in the start bit of a frame with bytes queued
    step(101);                        // M+202
    check("ar_tx_low",   {31'd0, tx0}, 32'd0);
    check("ar_queued",   {31'd0, (bus0.count >= 5'd3)}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_tx",       {31'd0, tx0},           32'd1);
    check("ar_busy",     {31'd0, bus0.busy},     32'd0);
    check("ar_count",    {27'd0, bus0.count},    32'd0);
    check("ar_overflow", {31'd0, bus0.overflow}, 32'd0);
    step(2);
    rst_n = 1'b1;
    low_seen = 0;
    for (int c = 0; c < 300; c++) begin
      step(1);
      if (tx0 !== 1'b1) low_seen++;
    end
    check("ar_quiet",      low_seen, 32'd0);
    check("ar_busy_after", {31'd0, bus0.busy}, 32'd0);
    rx_q.delete();

    // Fill to full behind a busy FSM, then one overflowing write
    write0(8'hC0);
    step(1);
    for (int k = 0; k < 17; k++) begin
      bus0.wr_en   = 1'b1;
      bus0.wr_data = 8'(k + 1);
      step(1);
      if (k == 15) begin
        check("ov_full16",  {31'd0, bus0.full},     32'd1);
        check("ov_count16", {27'd0, bus0.count},    32'd16);
        check("ov_ovf16",   {31'd0, bus0.overflow}, 32'd0);
      end
      if (k == 16) begin
        check("ov_ovf17",   {31'd0, bus0.overflow}, 32'd1);
        check("ov_count17", {27'd0, bus0.count},    32'd16);
      end
    end
    bus0.wr_en = 1'b0;
    for (int c = 0; c < 2100 && rx_q.size() < 17; c++) step(1);
    check("ov_frames", rx_q.size(), 32'd17);
    step(200);
    check("ov_frames_final", rx_q.size(), 32'd17);
    check("ov_idle", {31'd0, bus0.busy}, 32'd0);
    if (rx_q.size() == 17) begin
      check("ov_byte0", {24'd0, rx_q[0]}, 32'hC0);
      for (int i = 1; i < 17; i++) begin
        check($sformatf("ov_byte%0d", i), {24'd0, rx_q[i]}, i);
      end
    end

    // Rounded divider: 9 clocks per bit
    bus1.wr_en   = 1'b1;
    bus1.wr_data = 8'hFF;
    step(1);                          // edge N
    bus1.wr_en = 1'b0;
    check("d9_tx_N", {31'd0, tx1}, 32'd1);
    step(1);                          // N+1
    lo = 0;
    bz = 0;
    for (int c = 0; c < 200 && bus1.busy; c++) begin
      if (!tx1) lo++;
      bz++;
      step(1);
    end
    check("d9_start_width", lo, 32'd9);
    check("d9_frame_len",   bz, 32'd90);
    check("d9_tx_idle",     {31'd0, tx1}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
